// File: rtl/int_issue_queue_if.sv
// Entry format shared by dispatch, the issue queue and the ALU, plus the
// handshake bundle between the integer issue queue and its neighbours.
package int_issue_queue_pkg;
  localparam int ROB_ID_WIDTH = 5;

  typedef struct packed {
    logic [7:0]              opcode;
    logic                    dst_valid;
    logic [ROB_ID_WIDTH-1:0] instr_rob_id;
    logic                    src1_valid;
    logic                    src1_ready;
    logic [ROB_ID_WIDTH-1:0] src1_rob_id;
    logic [31:0]             src1_data;
    logic                    src2_valid;
    logic                    src2_ready;
    logic [ROB_ID_WIDTH-1:0] src2_rob_id;
    logic [31:0]             src2_data;
  } iiq_entry_t;
endpackage

interface int_issue_queue_if;
  import int_issue_queue_pkg::*;

  logic                    iiq_dispatch_ready;
  logic                    iiq_dispatch_valid;
  iiq_entry_t              iiq_dispatch_data;
  logic                    alu_broadcast_valid;
  logic [ROB_ID_WIDTH-1:0] alu_broadcast_rob_id;
  logic [31:0]             alu_broadcast_reg_data;
  logic                    ld_broadcast_valid;
  logic [ROB_ID_WIDTH-1:0] ld_broadcast_rob_id;
  logic [31:0]             ld_broadcast_reg_data;
  logic                    alu_issue_ready;
  logic                    alu_issue_valid;
  iiq_entry_t              alu_issue_data;
  logic                    iiq_wakeup_valid;
  logic [ROB_ID_WIDTH-1:0] iiq_wakeup_rob_id;
  logic                    fetch_redirect_valid;

  modport master (
    input  iiq_dispatch_ready, alu_issue_valid, alu_issue_data,
           iiq_wakeup_valid, iiq_wakeup_rob_id,
    output iiq_dispatch_valid, iiq_dispatch_data,
           alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
           ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data,
           alu_issue_ready, fetch_redirect_valid
  );

  modport slave (
    output iiq_dispatch_ready, alu_issue_valid, alu_issue_data,
           iiq_wakeup_valid, iiq_wakeup_rob_id,
    input  iiq_dispatch_valid, iiq_dispatch_data,
           alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
           ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data,
           alu_issue_ready, fetch_redirect_valid
  );
endinterface

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered compacting entry array (slot 0 oldest),
// tag-based operand wakeup/capture, oldest-ready select with broadcast bypass.
module iiq_entry_view
  import int_issue_queue_pkg::*;
(
  input  iiq_entry_t              entry,
  input  logic                    wake_valid,
  input  logic [ROB_ID_WIDTH-1:0] wake_rob_id,
  input  logic                    ld_valid,
  input  logic [ROB_ID_WIDTH-1:0] ld_rob_id,
  input  logic [31:0]             ld_data,
  input  logic                    alu_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]             alu_data,
  output iiq_entry_t              view
);
  logic [1:0] wk, ld, alu;

  // Data capture is not gated by src_ready: a wakeup sets ready before the
  // producer's ALU result shows up one cycle later.
  assign wk[0]  = entry.src1_valid && wake_valid && (entry.src1_rob_id == wake_rob_id);
  assign wk[1]  = entry.src2_valid && wake_valid && (entry.src2_rob_id == wake_rob_id);
  assign ld[0]  = entry.src1_valid && ld_valid   && (entry.src1_rob_id == ld_rob_id);
  assign ld[1]  = entry.src2_valid && ld_valid   && (entry.src2_rob_id == ld_rob_id);
  assign alu[0] = entry.src1_valid && alu_valid  && (entry.src1_rob_id == alu_rob_id);
  assign alu[1] = entry.src2_valid && alu_valid  && (entry.src2_rob_id == alu_rob_id);

  always_comb begin
    view            = entry;
    view.src1_ready = entry.src1_ready | wk[0] | ld[0];
    view.src2_ready = entry.src2_ready | wk[1] | ld[1];
    view.src1_data  = alu[0] ? alu_data : (ld[0] ? ld_data : entry.src1_data);
    view.src2_data  = alu[1] ? alu_data : (ld[1] ? ld_data : entry.src2_data);
  end
endmodule

module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int CNT_WIDTH = $clog2(N_ENTRIES) + 1
) (
  input logic               clk,
  input logic               rst_aH,
  int_issue_queue_if.slave  iiq
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  iiq_entry_t             ent     [N_ENTRIES];
  iiq_entry_t             ent_nxt [N_ENTRIES];
  iiq_entry_t             cand    [N_ENTRIES+1];
  iiq_entry_t             view    [N_ENTRIES+1];
  logic [N_ENTRIES-1:0]   vld, vld_nxt, issuable;
  logic [CNT_WIDTH-1:0]   count, count_nxt, wr_pos;
  logic [IDX_W-1:0]       sel;
  logic                   any_rdy, fire, disp_fire, flush;

  assign flush     = iiq.fetch_redirect_valid;
  assign iiq.iiq_dispatch_ready = (count < CNT_WIDTH'(N_ENTRIES));
  assign disp_fire = iiq.iiq_dispatch_valid && iiq.iiq_dispatch_ready && !flush;

  // Slot N_ENTRIES is the incoming dispatch entry so it sees the same wakeups.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) cand[i] = ent[i];
    cand[N_ENTRIES] = iiq.iiq_dispatch_data;
  end

  for (genvar g = 0; g <= N_ENTRIES; g++) begin : g_view
    iiq_entry_view u_view (
      .entry       (cand[g]),
      .wake_valid  (iiq.iiq_wakeup_valid),
      .wake_rob_id (iiq.iiq_wakeup_rob_id),
      .ld_valid    (iiq.ld_broadcast_valid),
      .ld_rob_id   (iiq.ld_broadcast_rob_id),
      .ld_data     (iiq.ld_broadcast_reg_data),
      .alu_valid   (iiq.alu_broadcast_valid),
      .alu_rob_id  (iiq.alu_broadcast_rob_id),
      .alu_data    (iiq.alu_broadcast_reg_data),
      .view        (view[g])
    );
  end

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_rdy
    assign issuable[g] = vld[g] && (!ent[g].src1_valid || ent[g].src1_ready)
                                && (!ent[g].src2_valid || ent[g].src2_ready);
  end

  // Lowest slot is oldest, so scan downward and keep the last hit.
  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (issuable[i]) begin
        any_rdy = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  assign iiq.alu_issue_valid   = any_rdy && !flush;
  assign fire                  = iiq.alu_issue_valid && iiq.alu_issue_ready;
  assign iiq.alu_issue_data    = iiq.alu_issue_valid ? view[sel] : '0;
  assign iiq.iiq_wakeup_valid  = fire && ent[sel].dst_valid;
  assign iiq.iiq_wakeup_rob_id = fire ? ent[sel].instr_rob_id : '0;

  assign wr_pos = count - CNT_WIDTH'(fire);

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) ent_nxt[i] = view[i];
    vld_nxt   = vld;
    count_nxt = count + CNT_WIDTH'(disp_fire) - CNT_WIDTH'(fire);
    if (fire) begin
      for (int i = 0; i < N_ENTRIES - 1; i++) begin
        if (i >= int'(sel)) begin
          ent_nxt[i] = view[i+1];
          vld_nxt[i] = vld[i+1];
        end
      end
      vld_nxt[N_ENTRIES-1] = 1'b0;
    end
    if (disp_fire) begin
      ent_nxt[wr_pos[IDX_W-1:0]] = view[N_ENTRIES];
      vld_nxt[wr_pos[IDX_W-1:0]] = 1'b1;
    end
    if (flush) begin
      vld_nxt   = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int i = 0; i < N_ENTRIES; i++) ent[i] <= '0;
      vld   <= '0;
      count <= '0;
    end else begin
      ent   <= ent_nxt;
      vld   <= vld_nxt;
      count <= count_nxt;
    end
  end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer issue queue (IIQ) directly downstream of dispatch.
- Accepts renamed integer instructions (iiq_entry_t) over a ready/valid handshake and tracks operand readiness by ROB tag.
- Captures operand data from ALU and load broadcasts, and issues the oldest ready instruction to the ALU each cycle.
- Drives the integer wakeup tag back to dispatch, and flushes completely on fetch redirect.

Parameters:
- N_ENTRIES, 8, queue depth; power of two, 2..16.
- CNT_WIDTH, $clog2(N_ENTRIES)+1, occupancy counter width.

Ports:
- clk  in  1  clock
- rst_aH  in  1  reset, asynchronous, active-high
- iiq_dispatch_ready  out  1  queue can accept an entry this cycle
- iiq_dispatch_valid  in  1  dispatch offers an entry
- iiq_dispatch_data  in  iiq_entry_t  renamed instruction, srcs possibly not ready
- alu_broadcast_valid  in  1  ALU result writeback
- alu_broadcast_rob_id  in  ROB_ID_WIDTH  producer tag
- alu_broadcast_reg_data  in  32  result
- ld_broadcast_valid  in  1  load writeback
- ld_broadcast_rob_id  in  ROB_ID_WIDTH  producer tag
- ld_broadcast_reg_data  in  32  load data
- alu_issue_ready  in  1  ALU accepts an instruction
- alu_issue_valid  out  1  issue offer
- alu_issue_data  out  iiq_entry_t  issued entry, both src data fields final
- iiq_wakeup_valid  out  1  issued instruction writes rd
- iiq_wakeup_rob_id  out  ROB_ID_WIDTH  instr_rob_id of the issued instruction
- fetch_redirect_valid  in  1  flush

Behaviour:
- Reset (async, rst_aH=1): all entries invalid, count=0, age order cleared.
- Outputs during reset: iiq_dispatch_ready=1, alu_issue_valid=0, iiq_wakeup_valid=0, alu_issue_data=0.
- Dispatch handshake:
  - iiq_dispatch_ready = (count < N_ENTRIES); depends only on registered state, never on same-cycle issue.
  - Entry written at the edge when valid && ready && !fetch_redirect_valid.
  - Latency: an entry dispatched at edge t is issuable in cycle t+1 at the earliest.
- Operand readiness:
  - A src is ready if src_valid=0 or src_ready=1.
  - Each cycle, every valid entry with a not-ready src compares src_rob_id against three tags:
    - iiq_wakeup_rob_id (when iiq_wakeup_valid): set ready; data arrives later via ALU broadcast.
    - ld_broadcast_rob_id (when ld_broadcast_valid): set ready and capture data.
    - alu_broadcast_rob_id (when alu_broadcast_valid): capture data.
  - The same comparisons apply to the entry being written this cycle, so there is no lost wakeup between dispatch and queue.
- Select:
  - Pick the oldest valid entry (dispatch order) with both srcs ready.
  - alu_issue_valid=1 when one exists and fetch_redirect_valid=0.
  - Select is combinational from registered state plus the bypass below.
- Issue data bypass: for each src, if alu_broadcast_valid and the tag matches, output alu_broadcast_reg_data. Otherwise output ld_broadcast_reg_data on a load match, otherwise stored data.
  - This covers a dependent woken at t issuing at t+1 while the producer broadcasts at t+1.
- Issue handshake:
  - On alu_issue_valid && alu_issue_ready, the entry is freed at the edge. Younger entries keep their relative order.
  - If !alu_issue_ready, nothing is freed and the selection may change next cycle.
- Wakeup: iiq_wakeup_valid = issue handshake && dst_valid, same cycle; iiq_wakeup_rob_id = issued instr_rob_id.
- Occupancy:
  - count next = count + dispatch - issue.
  - Simultaneous dispatch and issue when full is impossible, since ready=0 when full.
  - When count = N_ENTRIES-1, simultaneous dispatch and issue leaves count unchanged.
- Flush: fetch_redirect_valid=1 clears all entries and sets count=0 at the edge. In that cycle dispatch is ignored and issue and wakeup are suppressed.
- Reset mid-operation: immediate clear; no partial state survives.

Test Plan:
- Dispatch addi with src1_ready=1, rob_id 3, dst_valid=1; alu_issue_ready=1 -> issue next cycle with src1_data intact; iiq_wakeup_valid=1, iiq_wakeup_rob_id=3; count returns to 0.
- Dispatch A (rob 2, ready) then B (src1_rob_id=2, not ready):
  - A issues at t -> B src1 ready at t+1.
  - At t+1 alu_broadcast (rob 2, 0x1234) -> B issues at t+1 with src1_data=0x1234.
- Fill 8 entries all not-ready, alu_issue_ready=1 -> iiq_dispatch_ready=0; the 9th offer is held.
- ld_broadcast rob 5 with data 0xDEAD -> two entries (oldest first) issue in dispatch order on successive cycles.
- Entries rob 1 and rob 4 both ready, alu_issue_ready=0 for 3 cycles -> alu_issue_valid held with rob 1 data stable. Then ready=1 -> rob 1 issues, then rob 4.
- Queue holds 5 entries; assert fetch_redirect_valid together with a dispatch -> next cycle count=0, no issue, dispatch dropped. Async rst_aH pulse mid-stream -> outputs at reset values immediately.
